// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared constants, types and helpers for the interrupt aggregator.
//   - Register byte offsets within the APB window.
//   - MAX_SRC: the width of the IREQ bus, fixed at 8.
//   - intr_vec_t: a vector with one bit per source.
//   - prio_enc: finds the lowest-index set bit. Index 0 has the highest priority.
package intr_ctrl_pkg;

    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned DATA_W  = 32;

    localparam logic [4:0] ENABLE_OFF = 5'h00;
    localparam logic [4:0] MODE_OFF   = 5'h04;
    localparam logic [4:0] STATUS_OFF = 5'h08;
    localparam logic [4:0] IREQ_OFF   = 5'h0C;
    localparam logic [4:0] VECTOR_OFF = 5'h10;

    typedef logic [MAX_SRC-1:0] intr_vec_t;

    // Returns {valid, idx[2:0]}. Scanning downwards lets the lowest set index win.
    function automatic logic [3:0] prio_enc(input intr_vec_t v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = int'(MAX_SRC) - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_src_cell.sv
// intr_src_cell: per-source pending logic.
//   Ports:
//     clk_i, rst_i   clock; synchronous active-high reset
//     src_i          raw source line
//     mode_i         1 = edge, 0 = level
//     w1c_i          software clear; affects edge mode only
//     pending_o      pending flag
//   Optional: when INTR_CTRL_SYNC_EN is defined, the source passes through a
//   2-flop synchronizer before the mode logic.
module intr_src_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic mode_i,
    input  logic w1c_i,
    output logic pending_o
);

    logic src_s;

`ifdef INTR_CTRL_SYNC_EN
    logic [1:0] sync_q;

    // Synchronizer. It is reset to 0, so a source held high through reset
    // produces a fresh rising edge once the chain refills.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], src_i};
    end
    assign src_s = sync_q[1];
`else
    assign src_s = src_i;
`endif

    logic src_q;
    logic pending_q;
    logic pending_d;
    logic rise_c;

    assign rise_c = src_s & ~src_q;

    // Level mode follows the source directly.
    // Edge mode latches the edge. A rising edge beats a clear in the same cycle.
    always_comb begin
        pending_d = pending_q;
        if (mode_i) pending_d = rise_c | (pending_q & ~w1c_i);
        else        pending_d = src_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            src_q     <= src_s;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt aggregator with a zero-wait APB slave.
//   Ports:
//     PCLK, PRESET      clock; synchronous active-high reset
//     src_i[NUM_SRC]    raw interrupt sources
//     PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY   APB slave
//     IREQ[7:0]         registered pending & enable
//     IRQ               registered OR of IREQ
//   Register map (PADDR[4:2] decoded):
//     0x00 ENABLE, 0x04 MODE, 0x08 STATUS (W1C), 0x0C IREQ, 0x10 VECTOR
//   Optional: INTR_CTRL_SYNC_EN adds a 2-flop synchronizer on every source.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_SRC-1:0]  src_i,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic [MAX_SRC-1:0]  IREQ,
    output logic                IRQ
);

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] pending_c;
    logic [NUM_SRC-1:0] w1c_c;
    intr_vec_t          ireq_q, ireq_d;
    logic               irq_q, irq_d;
    logic [4:0]         off_c;
    logic               wr_c;
    logic               rd_c;
    logic [3:0]         vec_c;
    logic               unused_c;

    assign off_c    = {PADDR[4:2], 2'b00};
    assign wr_c     = PSEL & PENABLE & PWRITE;
    assign rd_c     = PSEL & PENABLE;
    assign unused_c = ^{PADDR[ADDR_W-1:5], PADDR[1:0], PWDATA[DATA_W-1:NUM_SRC]};

    // Register write decode. Writes to unmapped offsets are ignored.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c_c    = '0;
        if (wr_c) begin
            case (off_c)
                ENABLE_OFF: enable_d = PWDATA[NUM_SRC-1:0];
                MODE_OFF:   mode_d   = PWDATA[NUM_SRC-1:0];
                STATUS_OFF: w1c_c    = PWDATA[NUM_SRC-1:0];
                default:    ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        intr_src_cell u_cell (
            .clk_i     (PCLK),
            .rst_i     (PRESET),
            .src_i     (src_i[i]),
            .mode_i    (mode_q[i]),
            .w1c_i     (w1c_c[i]),
            .pending_o (pending_c[i])
        );
    end

    // IREQ bits at or above NUM_SRC are zero-filled.
    assign ireq_d = intr_vec_t'(pending_c & enable_q);
    assign irq_d  = |ireq_d;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            enable_q <= '0;
            mode_q   <= '0;
            ireq_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            ireq_q   <= ireq_d;
            irq_q    <= irq_d;
        end
    end

    assign vec_c = prio_enc(ireq_q);

    // Combinational read mux. It outputs zero outside the access phase.
    always_comb begin
        PRDATA = '0;
        if (rd_c) begin
            case (off_c)
                ENABLE_OFF: PRDATA = DATA_W'(enable_q);
                MODE_OFF:   PRDATA = DATA_W'(mode_q);
                STATUS_OFF: PRDATA = DATA_W'(pending_c);
                IREQ_OFF:   PRDATA = DATA_W'(ireq_q);
                VECTOR_OFF: PRDATA = {vec_c[3], 28'd0, vec_c[2:0]};
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY = 1'b1;
    assign IREQ   = ireq_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk;
    logic        PRESET;
    logic [7:0]  src;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [7:0]  IREQ;
    logic        IRQ;

    int n_checks = 0;
    int n_pass   = 0;

    intr_ctrl #(.NUM_SRC(8), .ADDR_W(8)) dut (
        .PCLK    (clk),
        .PRESET  (PRESET),
        .src_i   (src),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .IREQ    (IREQ),
        .IRQ     (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model state: register contents as seen after each clock edge.
    logic [7:0] m_en, m_mode, m_pend, m_prev, m_ireq, h0, h1;
    logic       m_ready = 1'b0;

    always @(posedge clk) begin
        logic [7:0] s, w1c, rise;
        logic       wr;
        if (PRESET) begin
            m_en <= 8'h0; m_mode <= 8'h0; m_pend <= 8'h0; m_prev <= 8'h0;
            m_ireq <= 8'h0; h0 <= 8'h0; h1 <= 8'h0; m_ready <= 1'b1;
        end else begin
`ifdef INTR_CTRL_SYNC_EN
            s = h1;
            h1 <= h0;
            h0 <= src;
`else
            s = src;
`endif
            wr   = PSEL && PENABLE && PWRITE;
            w1c  = (wr && PADDR[4:2] == 3'd2) ? PWDATA[7:0] : 8'h0;
            rise = s & ~m_prev;
            // Edge bits: a new edge sets the bit, and W1C clears held bits.
            // Level bits copy the source.
            m_pend <= (m_mode & (rise | (m_pend & ~w1c))) | (~m_mode & s);
            m_prev <= s;
            m_ireq <= m_pend & m_en;
            if (wr && PADDR[4:2] == 3'd0) m_en   <= PWDATA[7:0];
            if (wr && PADDR[4:2] == 3'd1) m_mode <= PWDATA[7:0];
        end
    end

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        r = 32'h0;
        if (PSEL && PENABLE) begin
            case (PADDR[4:2])
                3'd0: r = {24'h0, m_en};
                3'd1: r = {24'h0, m_mode};
                3'd2: r = {24'h0, m_pend};
                3'd3: r = {24'h0, m_ireq};
                3'd4: begin
                    for (int i = 7; i >= 0; i--)
                        if (m_ireq[i]) r = 32'h8000_0000 | 32'(i);
                end
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // Per-cycle compare against the model. Sampling happens away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("ireq", 32'(IREQ), 32'(m_ireq));
            chk("irq", 32'(IRQ), 32'(m_ireq != 8'h0));
            chk("prdata", PRDATA, exp_rd());
            chk("pready", 32'(PREADY), 32'h1);
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        drive(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        drive(); PENABLE = 1'b1;
        drive(); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        drive(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        drive(); PENABLE = 1'b1;
        @(negedge clk); d = PRDATA;
        drive(); PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        PRESET = 1'b0; src = 8'h0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h0; PWDATA = 32'h0;

        // 1: reset, then a level source on bit 0
        drive(); PRESET = 1'b1;
        drive(); PRESET = 1'b0;
        @(negedge clk);
        chk("rst_ireq", 32'(IREQ), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        apb_wr(8'h00, 32'h01);
        apb_wr(8'h04, 32'h00);
        drive(); src = 8'h01;
        wait_neg(2 + SL);
        chk("lvl_rise_1clk", 32'(IREQ), 32'h00);
        wait_neg(1);
        chk("lvl_rise_ireq", 32'(IREQ), 32'h01);
        chk("lvl_rise_irq", 32'(IRQ), 32'h1);
        drive(); src = 8'h00;
        wait_neg(3 + SL);
        chk("lvl_fall_irq", 32'(IRQ), 32'h0);

        // 2: edge source on bit 2 with a W1C clear
        apb_wr(8'h04, 32'h04);
        apb_wr(8'h00, 32'h04);
        drive(); src = 8'h04;
        drive(); src = 8'h00;
        wait_neg(4 + SL);
        chk("edge_irq", 32'(IRQ), 32'h1);
        apb_rd(8'h08, rd);
        chk("edge_status", rd, 32'h04);
        apb_wr(8'h08, 32'h04);
        @(negedge clk);
        chk("w1c_irq_hold", 32'(IRQ), 32'h1);
        @(negedge clk);
        chk("w1c_irq_clr", 32'(IRQ), 32'h0);

        // 3: an edge in the same cycle as W1C; the set is kept
        drive(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h04;
        drive(); PENABLE = 1'b1; src = 8'h04;
        drive(); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; src = 8'h00;
        wait_neg(2 + SL);
        apb_rd(8'h08, rd);
        chk("set_wins_status", rd, 32'h04);
        chk("set_wins_irq", 32'(IRQ), 32'h1);
        apb_wr(8'h08, 32'h04);

        // 4: a masked edge on bit 5, enabled later
        apb_wr(8'h00, 32'h00);
        apb_wr(8'h04, 32'h24);
        drive(); src = 8'h20;
        drive(); src = 8'h00;
        wait_neg(3 + SL);
        apb_rd(8'h08, rd);
        chk("masked_status", rd, 32'h20);
        chk("masked_ireq", 32'(IREQ), 32'h00);
        apb_wr(8'h00, 32'h20);
        @(negedge clk);
        @(negedge clk);
        chk("unmask_ireq", 32'(IREQ), 32'h20);
        apb_rd(8'h10, rd);
        chk("vector5", rd, 32'h8000_0005);

        // 5: vector priority between two level sources
        apb_wr(8'h04, 32'h00);
        apb_wr(8'h00, 32'h48);
        drive(); src = 8'h48;
        wait_neg(3 + SL);
        apb_rd(8'h10, rd);
        chk("vector3", rd, 32'h8000_0003);
        drive(); src = 8'h40;
        wait_neg(3 + SL);
        apb_rd(8'h10, rd);
        chk("vector6", rd, 32'h8000_0006);
        apb_rd(8'h1C, rd);
        chk("unmapped_rd", rd, 32'h0);

        // 6: reset while an edge is pending and IRQ is high
        drive(); src = 8'h00;
        apb_wr(8'h04, 32'h02);
        apb_wr(8'h00, 32'h02);
        drive(); src = 8'h02;
        drive(); src = 8'h00;
        wait_neg(3 + SL);
        chk("pre_rst_irq", 32'(IRQ), 32'h1);
        drive(); PRESET = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_ireq", 32'(IREQ), 32'h0);
        chk("mid_rst_irq", 32'(IRQ), 32'h0);
        drive(); PRESET = 1'b0;
        apb_rd(8'h08, rd);
        chk("mid_rst_status", rd, 32'h0);
        apb_rd(8'h00, rd);
        chk("mid_rst_enable", rd, 32'h0);

        // Random traffic checked by the per-cycle compare
        for (int c = 0; c < 3000; c++) begin
            drive();
            PRESET  = ($urandom_range(0, 199) == 0);
            src     = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            PSEL    = 1'($urandom);
            PENABLE = 1'($urandom);
            PWRITE  = 1'($urandom);
            PADDR   = 8'($urandom_range(0, 47));
            PWDATA  = $urandom;
        end
        drive(); PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        wait_neg(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
